// File: rtl/boot_loader_pkg.sv
// Shared constants and state encoding for the boot loader and its byte/word packer.
package boot_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CHK_W  = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_SCAN_RD,
        ST_SCAN_CAP,
        ST_SCAN_TX,
        ST_ERR
    } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Bidirectional byte<->word converter: assembles bytes into a word MSB-first,
// or serialises a loaded word MSB byte first. Both directions share one register.
module byte_word_packer
    import boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              clr,
    input  logic              shift_in,
    input  logic [7:0]        byte_in,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              shift_out,
    output logic [DATA_W-1:0] word_next_c,
    output logic [7:0]        byte_out,
    output logic              last_c
);

    localparam int unsigned BYTES = DATA_W / BYTE_W;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    assign word_next_c = (word_q << BYTE_W) | DATA_W'(byte_in);
    assign byte_out    = word_q[DATA_W-1 -: BYTE_W];
    // High while the current byte transfer is the one that completes the word.
    assign last_c      = (cnt_q == CNT_W'(BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (ce) begin
            if (load) begin
                word_q <= word_in;
                cnt_q  <= '0;
            end else if (shift_in) begin
                word_q <= word_next_c;
                cnt_q  <= last_c ? '0 : cnt_q + CNT_W'(1);
            end else if (shift_out) begin
                word_q <= word_q << BYTE_W;
                cnt_q  <= last_c ? '0 : cnt_q + CNT_W'(1);
            end else if (clr) begin
                cnt_q  <= '0;
            end
        end
    end

endmodule

// File: rtl/boot_loader_gen2.sv
// Boot loader: loads a checksummed program image into RAM from a byte stream,
// releases the CPU on a good image, and dumps RAM back out on request.
module boot_loader_gen2
    import boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 6,
    parameter bit          RETRY_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              scan_memory,
    input  logic [DATA_W-1:0] ram_out,
    output logic              boot,
    output logic              ram_rw,
    output logic              ram_enable,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in,
    output logic              load_err
);

    state_e             state_q, state_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [CHK_W-1:0]   csum_q, csum_n;
    logic               boot_n, load_err_n, tx_valid_n;
    logic               ram_rw_n, ram_enable_n;
    logic [ADDR_W-1:0]  ram_adr_n;
    logic [DATA_W-1:0]  ram_in_n;
    logic               scan_q, scan_edge_q;

    logic               pk_clr, pk_shift_in, pk_load, pk_shift_out, pk_last_c;
    logic [DATA_W-1:0]  pk_word_next_c;

    byte_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .clr         (pk_clr),
        .shift_in    (pk_shift_in),
        .byte_in     (rx_data),
        .load        (pk_load),
        .word_in     (ram_out),
        .shift_out   (pk_shift_out),
        .word_next_c (pk_word_next_c),
        .byte_out    (tx_data),
        .last_c      (pk_last_c)
    );

    // State, counters, edge detector and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            addr_q      <= '0;
            csum_q      <= '0;
            boot        <= 1'b1;
            load_err    <= 1'b0;
            tx_valid    <= 1'b0;
            ram_rw      <= RW_READ;
            ram_enable  <= 1'b0;
            ram_adr     <= '0;
            ram_in      <= '0;
            scan_q      <= 1'b0;
            scan_edge_q <= 1'b0;
        end else if (ce) begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            csum_q      <= csum_n;
            boot        <= boot_n;
            load_err    <= load_err_n;
            tx_valid    <= tx_valid_n;
            ram_rw      <= ram_rw_n;
            ram_enable  <= ram_enable_n;
            ram_adr     <= ram_adr_n;
            ram_in      <= ram_in_n;
            scan_q      <= scan_memory;
            scan_edge_q <= scan_memory & ~scan_q;
        end
    end

    // Next-state and next-output logic; RAM strobes are set on entry to the strobe state.
    always_comb begin
        state_n      = state_q;
        addr_n       = addr_q;
        csum_n       = csum_q;
        boot_n       = boot;
        load_err_n   = load_err;
        tx_valid_n   = 1'b0;
        ram_rw_n     = RW_READ;
        ram_enable_n = 1'b0;
        ram_adr_n    = '0;
        ram_in_n     = '0;
        pk_clr       = 1'b0;
        pk_shift_in  = 1'b0;
        pk_load      = 1'b0;
        pk_shift_out = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (rx_valid) begin
                    pk_shift_in = 1'b1;
                    csum_n      = csum_q + rx_data;
                    if (pk_last_c) begin
                        state_n      = ST_WRITE;
                        ram_enable_n = 1'b1;
                        ram_rw_n     = RW_WRITE;
                        ram_adr_n    = addr_q;
                        ram_in_n     = pk_word_next_c;
                    end
                end
            end
            ST_WRITE: begin
                addr_n  = addr_q + ADDR_W'(1);
                state_n = (addr_q == '1) ? ST_CHECK : ST_LOAD;
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        boot_n     = 1'b0;
                        load_err_n = 1'b0;
                        state_n    = ST_RUN;
                    end else begin
                        load_err_n = 1'b1;
                        csum_n     = '0;
                        addr_n     = '0;
                        pk_clr     = 1'b1;
                        state_n    = RETRY_ON_ERR ? ST_LOAD : ST_ERR;
                    end
                end
            end
            ST_RUN: begin
                if (scan_edge_q) begin
                    boot_n       = 1'b1;
                    addr_n       = '0;
                    state_n      = ST_SCAN_RD;
                    ram_enable_n = 1'b1;
                    ram_rw_n     = RW_READ;
                    ram_adr_n    = '0;
                end
            end
            ST_SCAN_RD: begin
                state_n = ST_SCAN_CAP;
            end
            ST_SCAN_CAP: begin
                pk_load    = 1'b1;
                tx_valid_n = 1'b1;
                state_n    = ST_SCAN_TX;
            end
            ST_SCAN_TX: begin
                tx_valid_n = 1'b1;
                if (tx_valid && tx_ready) begin
                    pk_shift_out = 1'b1;
                    if (pk_last_c) begin
                        tx_valid_n = 1'b0;
                        addr_n     = addr_q + ADDR_W'(1);
                        if (addr_q == '1) begin
                            boot_n  = 1'b0;
                            state_n = ST_RUN;
                        end else begin
                            state_n      = ST_SCAN_RD;
                            ram_enable_n = 1'b1;
                            ram_rw_n     = RW_READ;
                            ram_adr_n    = addr_q + ADDR_W'(1);
                        end
                    end
                end
            end
            ST_ERR: begin
                state_n = ST_ERR;
            end
            default: begin
                state_n = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader_gen2.sv
// Directed bench for boot_loader_gen2: load, checksum error/retry, scan dump,
// clock enable, mid-load reset, and halt-on-error configuration.
module tb_boot_loader_gen2;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst, ce, rx_valid, tx_ready, scan_memory;
    logic [7:0]        rx_data;
    logic              tx_valid, boot, ram_rw, ram_enable, load_err;
    logic [7:0]        tx_data;
    logic [DATA_W-1:0] ram_out, ram_in;
    logic [ADDR_W-1:0] ram_adr;

    logic              h_tx_valid, h_boot, h_ram_rw, h_ram_enable, h_load_err;
    logic [7:0]        h_tx_data;
    logic [DATA_W-1:0] h_ram_in;
    logic [DATA_W-1:0] h_ram_out = '0;
    logic [ADDR_W-1:0] h_ram_adr;

    logic [DATA_W-1:0] mem [4];
    logic              mem_clr = 1'b0;
    bit                ce_mode = 1'b0;
    int                h_strobes = 0;
    int                h_tx_cnt  = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    boot_loader_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RETRY_ON_ERR(1'b1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .scan_memory(scan_memory), .ram_out(ram_out), .boot(boot), .ram_rw(ram_rw),
        .ram_enable(ram_enable), .ram_adr(ram_adr), .ram_in(ram_in), .load_err(load_err)
    );

    boot_loader_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RETRY_ON_ERR(1'b0)) dut_h (
        .clk(clk), .rst(rst), .ce(ce), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(h_tx_valid), .tx_data(h_tx_data),
        .scan_memory(scan_memory), .ram_out(h_ram_out), .boot(h_boot), .ram_rw(h_ram_rw),
        .ram_enable(h_ram_enable), .ram_adr(h_ram_adr), .ram_in(h_ram_in), .load_err(h_load_err)
    );

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else        ram_out      <= mem[ram_adr];
        end
    end

    always @(posedge clk) begin
        if (h_ram_enable) h_strobes <= h_strobes + 1;
        if (h_tx_valid)   h_tx_cnt  <= h_tx_cnt + 1;
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(negedge clk);
            if (ce_mode) ce = ~ce;
            else         ce = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ce_edge();
        do @(posedge clk); while (ce !== 1'b1);
    endtask

    // Presents one byte until a ce-qualified edge accepts it; returns on the following negedge.
    task automatic send_byte(input logic [7:0] b);
        ce_edge();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ce_edge();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_words(input logic [63:0] img, input logic [7:0] cs, input bit ce_hold_chk);
        for (int i = 0; i < 8; i++) begin
            send_byte(img[63-8*i -: 8]);
            if (i == 1) begin
                chk("wr_en",   32'(ram_enable), 32'd1);
                chk("wr_rw",   32'(ram_rw),     32'd1);
                chk("wr_adr",  32'(ram_adr),    32'd0);
                chk("wr_data", 32'(ram_in),     32'(img[63:48]));
                if (ce_hold_chk) begin
                    @(negedge clk);
                    chk("ce_hold", 32'(ram_enable), 32'd1);
                end
            end
        end
        send_byte(cs);
    endtask

    task automatic chk_mem(input logic [63:0] img);
        for (int i = 0; i < 4; i++)
            chk($sformatf("mem%0d", i), 32'(mem[i]), 32'(img[63-16*i -: 16]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        scan_memory = 1'b0; mem_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        rst = 1'b1;
    endtask

    task automatic pulse_scan();
        @(negedge clk);
        scan_memory = 1'b1;
        @(negedge clk);
        scan_memory = 1'b0;
    endtask

    logic [63:0] img_a = 64'h1234_ABCD_0001_FF00;
    logic [63:0] img_b = 64'h0102_0304_0506_0708;

    initial begin
        logic [7:0] b;
        bit         stable, boot_hi, seen;
        int         snap_s, snap_t;

        rst = 1'b0;
        do_reset();

        // Reset values
        chk("rst_boot",  32'(boot),       32'd1);
        chk("rst_err",   32'(load_err),   32'd0);
        chk("rst_en",    32'(ram_enable), 32'd0);
        chk("rst_txv",   32'(tx_valid),   32'd0);
        chk("rst_adr",   32'(ram_adr),    32'd0);

        // Good load
        for (int i = 0; i < 8; i++) begin
            send_byte(img_a[63-8*i -: 8]);
            if (i == 1) begin
                chk("wr_en",   32'(ram_enable), 32'd1);
                chk("wr_data", 32'(ram_in),     32'h1234);
            end
        end
        chk("boot_pre_cs", 32'(boot), 32'd1);
        send_byte(8'hBE);
        chk("boot_fall", 32'(boot),     32'd0);
        chk("good_err",  32'(load_err), 32'd0);
        chk_mem(img_a);

        // Scan dump with 3-cycle tx_ready stall per byte
        pulse_scan();
        chk("scan_edge_reg", 32'(ram_enable), 32'd0);
        @(negedge clk);
        chk("scan_rd_en",  32'(ram_enable), 32'd1);
        chk("scan_rd_rw",  32'(ram_rw),     32'd0);
        chk("scan_rd_adr", 32'(ram_adr),    32'd0);
        chk("scan_boot",   32'(boot),       32'd1);
        @(negedge clk);
        chk("scan_cap_txv", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("scan_txv_rise", 32'(tx_valid), 32'd1);
        boot_hi = 1'b1;
        for (int k = 0; k < 8; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 10; t++) begin
                if (tx_valid) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            chk($sformatf("tx_wait%0d", k), 32'(seen), 32'd1);
            b = tx_data;
            chk($sformatf("tx_byte%0d", k), 32'(b), 32'(img_a[63-8*k -: 8]));
            stable = 1'b1;
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                if (!tx_valid || tx_data !== b) stable = 1'b0;
                if (!boot) boot_hi = 1'b0;
            end
            chk($sformatf("tx_hold%0d", k), 32'(stable), 32'd1);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk("scan_boot_hi",   32'(boot_hi),  32'd1);
        chk("scan_boot_done", 32'(boot),     32'd0);
        chk("scan_txv_done",  32'(tx_valid), 32'd0);

        // Bad checksum, then retry
        do_reset();
        load_words(img_a, 8'hBF, 1'b0);
        chk("bad_err",  32'(load_err), 32'd1);
        chk("bad_boot", 32'(boot),     32'd1);
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0;
        load_words(img_a, 8'hBE, 1'b0);
        chk("retry_boot", 32'(boot),     32'd0);
        chk("retry_err",  32'(load_err), 32'd0);
        chk_mem(img_a);

        // Clock enable toggling during a load
        do_reset();
        ce_mode = 1'b1;
        load_words(img_a, 8'hBE, 1'b1);
        chk("ce_boot", 32'(boot), 32'd0);
        ce_mode = 1'b0;
        @(negedge clk);
        chk_mem(img_a);

        // Reset in the middle of a load
        do_reset();
        send_byte(8'h12);
        send_byte(8'h34);
        chk("mid_en_pre", 32'(ram_enable), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_en",   32'(ram_enable), 32'd0);
        chk("mid_rw",   32'(ram_rw),     32'd0);
        chk("mid_in",   32'(ram_in),     32'd0);
        chk("mid_boot", 32'(boot),       32'd1);
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0; rst = 1'b1;
        load_words(img_b, 8'h24, 1'b0);
        chk("reload_boot", 32'(boot), 32'd0);
        chk_mem(img_b);

        // Halt-on-error configuration
        do_reset();
        load_words(img_a, 8'hBF, 1'b0);
        chk("halt_err",  32'(h_load_err), 32'd1);
        chk("halt_boot", 32'(h_boot),     32'd1);
        snap_s = h_strobes;
        snap_t = h_tx_cnt;
        load_words(img_a, 8'hBE, 1'b0);
        pulse_scan();
        repeat (10) @(negedge clk);
        chk("halt_boot2",   32'(h_boot),          32'd1);
        chk("halt_err2",    32'(h_load_err),      32'd1);
        chk("halt_strobes", 32'(h_strobes - snap_s), 32'd0);
        chk("halt_tx",      32'(h_tx_cnt - snap_t),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
